// File: rtl/addsub_arbiter.sv
// addsub_arbiter: round-robin sharing of one combinational sign-magnitude
// add/subtract unit between two requesters, one operation in flight at a time.
module addsub_arbiter #(
  parameter int unsigned WIDTH   = 4,
  parameter bit          RR_INIT = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic             req1,
  input  logic             op0,
  input  logic             op1,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b0,
  input  logic [WIDTH-1:0] b1,
  output logic             ack0,
  output logic             ack1,
  output logic [WIDTH-1:0] res,
  output logic             res_sign,
  output logic             res_carry,
  output logic             res_id,
  output logic             res_valid,
  output logic             busy,
  output logic [WIDTH-1:0] du_a,
  output logic [WIDTH-1:0] du_b,
  output logic             du_ctr,
  input  logic [WIDTH-1:0] du_s,
  input  logic             du_sign,
  input  logic             du_c1
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t state;
  logic   ptr;
  logic   grant1_c;

  // Requester 1 wins when it is alone or when both ask and it holds priority.
  assign grant1_c = req1 & (~req0 | ptr);

  // Arbitration FSM with all outputs registered; acks are single-cycle pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= RR_INIT;
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      res       <= '0;
      res_sign  <= 1'b0;
      res_carry <= 1'b0;
      res_id    <= 1'b0;
      res_valid <= 1'b0;
      busy      <= 1'b0;
      du_a      <= '0;
      du_b      <= '0;
      du_ctr    <= 1'b0;
    end else begin
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      res_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req0 | req1) begin
            du_ctr <= grant1_c ? op1 : op0;
            du_a   <= grant1_c ? a1 : a0;
            du_b   <= grant1_c ? b1 : b0;
            res_id <= grant1_c;
            busy   <= 1'b1;
            state  <= ISSUE;
          end
        end
        ISSUE: begin
          state <= CAPTURE;
        end
        CAPTURE: begin
          res       <= du_s;
          res_sign  <= du_sign;
          res_carry <= du_c1;
          state     <= DONE;
        end
        DONE: begin
          ack0      <= ~res_id;
          ack1      <= res_id;
          res_valid <= 1'b1;
          ptr       <= ~res_id;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_addsub_arbiter.sv
// Bench for addsub_arbiter: an operation-level model predicts every output each
// cycle, and directed tests pin acks and results against literal values.
module tb_addsub_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0, req1, op0, op1;
  logic [3:0] a0, a1, b0, b1;
  logic       ack0, ack1;
  logic [3:0] res;
  logic       res_sign, res_carry, res_id, res_valid, busy;
  logic [3:0] du_a, du_b;
  logic       du_ctr;
  logic [3:0] du_s;
  logic       du_sign, du_c1;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  addsub_arbiter #(.WIDTH(4), .RR_INIT(1'b0)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .op0(op0), .op1(op1),
    .a0(a0), .a1(a1), .b0(b0), .b1(b1),
    .ack0(ack0), .ack1(ack1), .res(res), .res_sign(res_sign),
    .res_carry(res_carry), .res_id(res_id), .res_valid(res_valid), .busy(busy),
    .du_a(du_a), .du_b(du_b), .du_ctr(du_ctr),
    .du_s(du_s), .du_sign(du_sign), .du_c1(du_c1)
  );

  // Attached add/sub unit: two's-complement adder, magnitude recovered on borrow.
  logic [4:0] dsum;
  always_comb begin
    if (du_ctr) dsum = {1'b0, du_a} + {1'b0, ~du_b} + 5'd1;
    else        dsum = {1'b0, du_a} + {1'b0, du_b};
    du_c1   = dsum[4];
    du_sign = du_ctr & ~dsum[4];
    du_s    = (du_ctr && !dsum[4]) ? 4'(5'd0 - dsum) : dsum[3:0];
  end

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Operation-level model: a grant schedules its result and ack a fixed number
  // of cycles later; the result comes from plain integer arithmetic.
  bit   armed = 1'b0;
  bit   m_ptr;
  int   m_left;          // cycles until the pending op acks, 0 = idle
  int   m_pend_res, m_pend_sign, m_pend_carry;
  int   e_ack0, e_ack1, e_res, e_sign, e_carry, e_id, e_valid, e_busy;
  int   e_da, e_db, e_ctr;

  always @(posedge clk) begin
    int w, a, b, o;
    if (!rst_n) begin
      armed = 1'b1; m_ptr = 1'b0; m_left = 0;
      e_ack0 = 0; e_ack1 = 0; e_res = 0; e_sign = 0; e_carry = 0;
      e_id = 0; e_valid = 0; e_busy = 0; e_da = 0; e_db = 0; e_ctr = 0;
    end else if (armed) begin
      e_ack0 = 0; e_ack1 = 0; e_valid = 0;
      if (m_left == 0) begin
        if (req0 || req1) begin
          w = (req0 && req1) ? int'(m_ptr) : (req1 ? 1 : 0);
          a = w ? int'(a1) : int'(a0);
          b = w ? int'(b1) : int'(b0);
          o = w ? int'(op1) : int'(op0);
          e_da = a; e_db = b; e_ctr = o; e_id = w;
          if (o == 0) begin
            m_pend_res = (a + b) % 16; m_pend_sign = 0; m_pend_carry = (a + b >= 16) ? 1 : 0;
          end else if (a >= b) begin
            m_pend_res = a - b; m_pend_sign = 0; m_pend_carry = 1;
          end else begin
            m_pend_res = b - a; m_pend_sign = 1; m_pend_carry = 0;
          end
          m_left = 3;
        end
      end else begin
        m_left--;
        if (m_left == 1) begin
          e_res = m_pend_res; e_sign = m_pend_sign; e_carry = m_pend_carry;
        end
        if (m_left == 0) begin
          e_ack0 = (e_id == 0); e_ack1 = (e_id == 1); e_valid = 1;
          m_ptr = (e_id == 0);
        end
      end
      e_busy = (m_left != 0);
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (armed) begin
      chk("m_ack0", ack0, e_ack0);
      chk("m_ack1", ack1, e_ack1);
      chk("m_res", res, e_res);
      chk("m_res_sign", res_sign, e_sign);
      chk("m_res_carry", res_carry, e_carry);
      chk("m_res_id", res_id, e_id);
      chk("m_res_valid", res_valid, e_valid);
      chk("m_busy", busy, e_busy);
      chk("m_du_a", du_a, e_da);
      chk("m_du_b", du_b, e_db);
      chk("m_du_ctr", du_ctr, e_ctr);
    end
  end

  // Waits (bounded) for the next ack and checks it against literal expectations.
  task automatic wait_ack(input int exp_id, input int exp_lat, input int e_r,
                          input int e_s, input int e_c);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(ack0 || ack1) && n < 12);
    chk("ack_seen", int'(ack0 | ack1), 1);
    chk("ack_latency", n, exp_lat);
    chk("ack0", ack0, (exp_id == 0) ? 1 : 0);
    chk("ack1", ack1, (exp_id == 1) ? 1 : 0);
    chk("res_valid", res_valid, 1);
    chk("res_id", res_id, exp_id);
    chk("res", res, e_r);
    chk("res_sign", res_sign, e_s);
    chk("res_carry", res_carry, e_c);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_acks"}, int'({ack1, ack0}), 0);
    chk({tag, "_res"}, int'({res_valid, res_id, res_carry, res_sign, res}), 0);
    chk({tag, "_du"}, int'({du_ctr, du_b, du_a}), 0);
  endtask

  initial begin
    // Reset with both requests high; requester 0 adds 9+8, requester 1 subs 3-5.
    rst_n = 1'b0;
    req0 = 1'b1; op0 = 1'b0; a0 = 4'd9; b0 = 4'd8;
    req1 = 1'b1; op1 = 1'b1; a1 = 4'd3; b1 = 4'd5;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;
    wait_ack(0, 4, 1, 0, 1);
    req0 = 1'b0;
    wait_ack(1, 4, 2, 1, 0);
    req1 = 1'b0;

    // Subtract equal operands.
    @(negedge clk);
    req1 = 1'b1; op1 = 1'b1; a1 = 4'd5; b1 = 4'd5;
    wait_ack(1, 4, 0, 0, 1);
    req1 = 1'b0;

    // Both requesting continuously: strict alternation every 4 cycles.
    @(negedge clk);
    req0 = 1'b1; op0 = 1'b0; a0 = 4'd3;  b0 = 4'd4;
    req1 = 1'b1; op1 = 1'b0; a1 = 4'd15; b1 = 4'd1;
    wait_ack(0, 4, 7, 0, 0);
    wait_ack(1, 4, 0, 0, 1);
    wait_ack(0, 4, 7, 0, 0);
    wait_ack(1, 4, 0, 0, 1);
    req0 = 1'b0; req1 = 1'b0;

    // Reset during ISSUE drops the op; the held request is served afterwards.
    @(negedge clk);
    req0 = 1'b1; op0 = 1'b1; a0 = 4'd6; b0 = 4'd2;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_zero("midreset");
    rst_n = 1'b1;
    wait_ack(0, 4, 4, 0, 1);
    req0 = 1'b0;

    // Operands changed while busy must not affect the result.
    @(negedge clk);
    req0 = 1'b1; op0 = 1'b1; a0 = 4'd2; b0 = 4'd7;
    @(negedge clk);
    op0 = 1'b0; a0 = 4'd15; b0 = 4'd15;
    wait_ack(0, 3, 5, 1, 0);
    req0 = 1'b0;

    repeat (4) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
